// File: rtl/pool_pkg.sv
// Shared lane width and lane comparison used by the max-pool stage.
// Comparison mode selects int8 or uint8 ordering per lane.
package pool_pkg;

  localparam int LANE_W = 8;

  // a > b under the selected lane interpretation
  function automatic logic lane_gt(
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b,
    input logic              signed_mode
  );
    if (signed_mode)
      return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/lane_max.sv
// Per-lane maximum of two packed beats.
// Pure compare-and-select: each lane equals one operand bit-for-bit.
module lane_max
  import pool_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic [LANE_W*SIZE-1:0] a,
  input  logic [LANE_W*SIZE-1:0] b,
  output logic [LANE_W*SIZE-1:0] y
);

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;

    assign la = a[k*LANE_W +: LANE_W];
    assign lb = b[k*LANE_W +: LANE_W];

    // pick b only when strictly larger; ties keep a
    assign y[k*LANE_W +: LANE_W] =
      lane_gt(lb, la, SIGNED) ? lb : la;
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over SIZE int8/uint8 lanes.
// Keeps one half-row of horizontal maxima; no frame memory.
module maxpool_2x2_stream
  import pool_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   sof_in,
  input  logic [LANE_W*SIZE-1:0] pixel_in,
  output logic                   valid_out,
  output logic                   eof_out,
  output logic [LANE_W*SIZE-1:0] pixel_out
);

  localparam int PW    = LANE_W * SIZE;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DEPTH = (WIDTH / 2 > 0) ? WIDTH / 2 : 1;
  localparam int HW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("maxpool_2x2_stream: WIDTH must be even and >= 2");
  end

  if (HEIGHT < 2 || (HEIGHT % 2) != 0) begin : g_bad_height
    $error("maxpool_2x2_stream: HEIGHT must be even and >= 2");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          col_last;
  logic          row_last;
  logic          odd_col;
  logic          odd_row;
  logic [HW-1:0] buf_idx;

  logic [PW-1:0] hold;
  logic [PW-1:0] row_buf [DEPTH];
  logic [PW-1:0] row_rd;
  logic [PW-1:0] h_max;
  logic [PW-1:0] v_max;

  logic          buf_we;
  logic          fire;
  logic          last;

  // sof_in forces this beat to (0,0); aborted partial windows are dropped
  always_comb begin
    cur_col  = sof_in ? '0 : col;
    cur_row  = sof_in ? '0 : row;
    col_last = (cur_col == COL_LAST);
    row_last = (cur_row == ROW_LAST);
    odd_col  = cur_col[0];
    odd_row  = cur_row[0];
    buf_idx  = HW'(cur_col >> 1);
    row_rd   = row_buf[buf_idx];
    buf_we   = valid_in & odd_col & ~odd_row;
    fire     = valid_in & odd_col & odd_row;
    last     = fire & col_last & row_last;
  end

  lane_max #(
    .SIZE   (SIZE),
    .SIGNED (SIGNED)
  ) u_hmax (
    .a (hold),
    .b (pixel_in),
    .y (h_max)
  );

  lane_max #(
    .SIZE   (SIZE),
    .SIGNED (SIGNED)
  ) u_vmax (
    .a (row_rd),
    .b (h_max),
    .y (v_max)
  );

  // raster position; advances only on accepted beats
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // left pixel of the current horizontal pair
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hold <= '0;
    else if (valid_in && !odd_col)
      hold <= pixel_in;
  end

  // half-row of horizontal maxima from the even row
  always_ff @(posedge clock) begin
    if (buf_we)
      row_buf[buf_idx] <= h_max;
  end

  // registered pooled beat, one cycle after the 4th window pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      pixel_out <= '0;
    end else begin
      valid_out <= fire;
      eof_out   <= last;
      if (fire)
        pixel_out <= v_max;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: signed and unsigned instances
// driven in parallel against a whole-frame reference model.
module tb_maxpool_2x2_stream;

  localparam int SZ = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PW = 8 * SZ;

  localparam logic [PW-1:0] F1 [8] = '{
    16'h0afb, 16'h14ff, 16'h037f, 16'h0480,
    16'hf9fe, 16'h0ff7, 16'h8000, 16'h0601
  };

  localparam logic [PW-1:0] F6 [8] = '{
    16'h0101, 16'h01ff, 16'h0101, 16'h0101,
    16'hff01, 16'h0101, 16'h0101, 16'hffff
  };

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          sof_in;
  logic [PW-1:0] pixel_in;
  logic          valid_out;
  logic          eof_out;
  logic [PW-1:0] pixel_out;
  logic          valid_out_u;
  logic          eof_out_u;
  logic [PW-1:0] pixel_out_u;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] img [H][W];
  int            pos;
  logic          ev;
  logic          ee;
  logic [PW-1:0] eps;
  logic [PW-1:0] epu;

  always #5 clock = ~clock;

  maxpool_2x2_stream #(
    .SIZE(SZ), .WIDTH(W), .HEIGHT(H), .SIGNED(1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .pixel_in  (pixel_in),
    .valid_out (valid_out),
    .eof_out   (eof_out),
    .pixel_out (pixel_out)
  );

  maxpool_2x2_stream #(
    .SIZE(SZ), .WIDTH(W), .HEIGHT(H), .SIGNED(1'b0)
  ) dut_u (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .pixel_in  (pixel_in),
    .valid_out (valid_out_u),
    .eof_out   (eof_out_u),
    .pixel_out (pixel_out_u)
  );

  function automatic logic [PW-1:0] wmax(
    input logic [PW-1:0] a, b, c, d,
    input bit sg
  );
    logic [PW-1:0] px [4];
    logic [PW-1:0] res;
    int m, v;
    px[0] = a; px[1] = b; px[2] = c; px[3] = d;
    res = '0;
    for (int k = 0; k < SZ; k++) begin
      m = -1000;
      for (int i = 0; i < 4; i++) begin
        if (sg) v = int'($signed(px[i][8*k +: 8]));
        else    v = int'(px[i][8*k +: 8]);
        if (v > m) m = v;
      end
      res[8*k +: 8] = 8'(m);
    end
    return res;
  endfunction

  task automatic step(input logic v, input logic s,
                      input logic [PW-1:0] p);
    int r, c;
    @(negedge clock);
    valid_in = v;
    sof_in   = s;
    pixel_in = p;
    ev = 1'b0;
    ee = 1'b0;
    if (v) begin
      if (s) pos = 0;
      r = pos / W;
      c = pos % W;
      img[r][c] = p;
      if ((r % 2) == 1 && (c % 2) == 1) begin
        ev  = 1'b1;
        ee  = (r == H - 1) && (c == W - 1);
        eps = wmax(img[r-1][c-1], img[r-1][c], img[r][c-1], p, 1'b1);
        epu = wmax(img[r-1][c-1], img[r-1][c], img[r][c-1], p, 1'b0);
      end
      pos = (pos + 1) % (W * H);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({valid_out, eof_out, pixel_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_s got v=%b e=%b p=%h want 0",
               valid_out, eof_out, pixel_out);
    end
    n_tests++;
    if ({valid_out_u, eof_out_u, pixel_out_u} !== '0) begin
      n_fail++;
      $display("FAIL reset_u got v=%b e=%b p=%h want 0",
               valid_out_u, eof_out_u, pixel_out_u);
    end
  endtask

  task automatic test_frame;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, F1[i]);
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps) ||
          valid_out_u !== ev || eof_out_u !== ee ||
          (ev && pixel_out_u !== epu)) begin
        n_fail++;
        $display("FAIL frame beat%0d got v=%b e=%b p=%h pu=%h want v=%b e=%b p=%h pu=%h",
                 i, valid_out, eof_out, pixel_out, pixel_out_u,
                 ev, ee, eps, epu);
      end
      if (i == 5 || i == 7) begin
        n_tests++;
        if (valid_out !== 1'b1 ||
            pixel_out !== ((i == 5) ? 16'h14ff : 16'h067f) ||
            eof_out !== (i == 7)) begin
          n_fail++;
          $display("FAIL frame_const beat%0d got v=%b e=%b p=%h",
                   i, valid_out, eof_out, pixel_out);
        end
      end
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b0, F1[i/2]);
      else            step(1'b0, (i == 5), 16'hdead);
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps) ||
          valid_out_u !== ev || (ev && pixel_out_u !== epu)) begin
        n_fail++;
        $display("FAIL gaps cyc%0d got v=%b e=%b p=%h want v=%b e=%b p=%h",
                 i, valid_out, eof_out, pixel_out, ev, ee, eps);
      end
    end
  endtask

  task automatic test_abort;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) step(1'b1, i == 0, 16'h7f7f);
      else       step(1'b1, i == 3, F1[i-3]);
      if (valid_out) pulses++;
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps)) begin
        n_fail++;
        $display("FAIL abort beat%0d got v=%b e=%b p=%h want v=%b e=%b p=%h",
                 i, valid_out, eof_out, pixel_out, ev, ee, eps);
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL abort_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, eofs;
    pulses = 0;
    eofs   = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i % 8) == 0, F1[i % 8]);
      if (valid_out) pulses++;
      if (eof_out) eofs++;
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps)) begin
        n_fail++;
        $display("FAIL b2b beat%0d got v=%b e=%b p=%h want v=%b e=%b p=%h",
                 i, valid_out, eof_out, pixel_out, ev, ee, eps);
      end
    end
    n_tests++;
    if (pulses != 4 || eofs != 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d/%0d want 4/2", pulses, eofs);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 6; i++)
      step(1'b1, i == 0, F1[i]);
    n_tests++;
    if (valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre got v=%b want 1", valid_out);
    end
    valid_in = 1'b0;
    sof_in   = 1'b0;
    reset    = 1'b1;
    #1;
    n_tests++;
    if ({valid_out, eof_out, pixel_out} !== '0 ||
        {valid_out_u, eof_out_u, pixel_out_u} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b e=%b p=%h want 0",
               valid_out, eof_out, pixel_out);
    end
    @(negedge clock);
    reset = 1'b0;
    pos   = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, F1[i]);
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps)) begin
        n_fail++;
        $display("FAIL rst_after beat%0d got v=%b e=%b p=%h want v=%b e=%b p=%h",
                 i, valid_out, eof_out, pixel_out, ev, ee, eps);
      end
    end
  endtask

  task automatic test_unsigned;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, F6[i]);
      if (i == 5 || i == 7) begin
        n_tests++;
        if (valid_out_u !== 1'b1 || pixel_out_u !== 16'hffff) begin
          n_fail++;
          $display("FAIL unsigned beat%0d got v=%b p=%h want 1 ffff",
                   i, valid_out_u, pixel_out_u);
        end
        n_tests++;
        if (valid_out !== 1'b1 || pixel_out !== 16'h0101) begin
          n_fail++;
          $display("FAIL signed01 beat%0d got v=%b p=%h want 1 0101",
                   i, valid_out, pixel_out);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
           PW'($urandom));
      n_tests++;
      if (valid_out !== ev || eof_out !== ee ||
          (ev && pixel_out !== eps) ||
          valid_out_u !== ev || eof_out_u !== ee ||
          (ev && pixel_out_u !== epu)) begin
        n_fail++;
        $display("FAIL random cyc%0d got v=%b e=%b p=%h pu=%h want v=%b e=%b p=%h pu=%h",
                 i, valid_out, eof_out, pixel_out, pixel_out_u,
                 ev, ee, eps, epu);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    pixel_in = '0;
    pos      = 0;
    ev       = 1'b0;
    ee       = 1'b0;
    eps      = '0;
    epu      = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset;
    @(negedge clock);
    reset = 1'b0;
    test_frame;
    test_gaps;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_unsigned;
    test_random;
    step(1'b0, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
